// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants, FSM encoding and hex-to-segment table for the scan driver
package seven_seg_pkg;
  localparam int NUM_DIGITS = 3;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [2:0] AN_OFF = 3'b111;
  typedef enum logic [1:0] {S_OFF, S_BLANK, S_DRIVE} state_t;
  // Active-low {g,f,e,d,c,b,a}, indexed by hex value 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/seven_seg_decoder.sv
// seven_seg_decoder: combinational 4-bit hex to active-low seven-segment pattern
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[hex];
endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: 3-digit common-anode scan driver with blanking and per-frame snapshot
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits 2 and 1.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int BLANK_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            scan_sel,
  input  logic                  enable,
  input  logic [11:0]           digits,
  input  logic [NUM_DIGITS-1:0] dp_in,
  output logic [2:0]            an,
  output logic [6:0]            seg,
  output logic                  seg_dp
);
  state_t state, nxt;
  logic [7:0] cnt;
  logic [1:0] sel_q;
  logic [11:0] snap_dig;
  logic [NUM_DIGITS-1:0] snap_dp;
  logic change, drive, blank_lz, dp_bit;
  logic [3:0] hex;
  logic [6:0] dec_seg;
  assign change = scan_sel != sel_q;
  assign nxt = !enable ? S_OFF :
               (state == S_OFF || change) ? S_BLANK :
               (state == S_BLANK && cnt == 8'd0) ? S_DRIVE : state;
  // Entering DRIVE implies no change, so sel_q already equals the incoming index
  assign drive = nxt == S_DRIVE && sel_q != 2'd3;
  assign hex = sel_q == 2'd2 ? snap_dig[11:8] : sel_q == 2'd1 ? snap_dig[7:4] : snap_dig[3:0];
  assign dp_bit = sel_q == 2'd2 ? snap_dp[2] : sel_q == 2'd1 ? snap_dp[1] : snap_dp[0];
`ifdef LEADING_ZERO_BLANK_EN
  assign blank_lz = (sel_q == 2'd2 && snap_dig[11:8] == 4'd0) ||
                    (sel_q == 2'd1 && snap_dig[11:4] == 8'd0);
`else
  assign blank_lz = 1'b0;
`endif
  seven_seg_decoder u_dec (.hex(hex), .seg(dec_seg));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_BLANK;
      cnt <= 8'd0;
      sel_q <= 2'd0;
      snap_dig <= 12'd0;
      snap_dp <= '0;
      an <= AN_OFF;
      seg <= SEG_BLANK;
      seg_dp <= 1'b1;
    end else begin
      sel_q <= scan_sel;
      state <= nxt;
      if (nxt == S_BLANK)
        cnt <= (state != S_BLANK || change) ? 8'(BLANK_CYCLES) : cnt - 8'd1;
      if ((state == S_OFF && enable) || (change && scan_sel == 2'd0)) begin
        snap_dig <= digits;
        snap_dp <= dp_in;
      end
      an <= drive ? ~(3'b001 << sel_q) : AN_OFF;
      seg <= (drive && !blank_lz) ? dec_seg : SEG_BLANK;
      seg_dp <= drive ? ~dp_bit : 1'b1;
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: directed checks for scan timing, blanking, snapshot and reset
module tb_seven_seg_scan_driver;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic LZ = 1'b1;
`else
  localparam logic LZ = 1'b0;
`endif
  logic clk = 0, rst_n = 0, enable = 1;
  logic [1:0] scan_sel = 0;
  logic [11:0] digits = 0;
  logic [2:0] dp_in = 0;
  logic [2:0] an0, an3;
  logic [6:0] seg0, seg3;
  logic seg_dp0, seg_dp3;
  int pass = 0, total = 0;
  logic [6:0] lz40;
  always #5 clk = ~clk;
  seven_seg_scan_driver #(.BLANK_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .scan_sel(scan_sel), .enable(enable), .digits(digits),
    .dp_in(dp_in), .an(an0), .seg(seg0), .seg_dp(seg_dp0));
  seven_seg_scan_driver #(.BLANK_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .scan_sel(scan_sel), .enable(enable), .digits(digits),
    .dp_in(dp_in), .an(an3), .seg(seg3), .seg_dp(seg_dp3));
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_reset_state;
    total++;
    if ({an0, seg0, seg_dp0} !== {3'b111, 7'h7F, 1'b1})
      $display("FAIL reset_state got an=%b seg=%h dp=%b want 111/7f/1", an0, seg0, seg_dp0);
    else pass++;
  endtask
  task automatic test_scan;
    scan_sel = 1; step(2);
    scan_sel = 2; step(2);
    digits = 12'h0A5; dp_in = 3'b010;
    for (int d = 0; d < 3; d++) begin
      logic [2:0] ea;
      logic [6:0] es;
      logic ed;
      ea = d == 0 ? 3'b110 : d == 1 ? 3'b101 : 3'b011;
      es = d == 0 ? 7'h12 : d == 1 ? 7'h08 : lz40;
      ed = d == 1 ? 1'b0 : 1'b1;
      scan_sel = 2'(d);
      step();
      total++;
      if ({an0, seg0, seg_dp0} !== {3'b111, 7'h7F, 1'b1})
        $display("FAIL scan_blank d%0d got an=%b seg=%h dp=%b want 111/7f/1", d, an0, seg0, seg_dp0);
      else pass++;
      for (int k = 0; k < 3; k++) begin
        step();
        total++;
        if ({an0, seg0, seg_dp0} !== {ea, es, ed})
          $display("FAIL scan_drive d%0d c%0d got an=%b seg=%h dp=%b want %b/%h/%b", d, k, an0, seg0, seg_dp0, ea, es, ed);
        else pass++;
      end
    end
  endtask
  task automatic test_blank;
    dp_in = 0;
    scan_sel = 0; step(6);
    total++;
    if ({an3, seg3} !== {3'b110, 7'h12})
      $display("FAIL blank3_pre got an=%b seg=%h want 110/12", an3, seg3);
    else pass++;
    scan_sel = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (an3 !== 3'b111)
        $display("FAIL blank3_off c%0d got an=%b want 111", k, an3);
      else pass++;
    end
    step();
    total++;
    if ({an3, seg3} !== {3'b101, 7'h08})
      $display("FAIL blank3_drive got an=%b seg=%h want 101/08", an3, seg3);
    else pass++;
  endtask
  task automatic test_tear;
    digits = 12'h123;
    scan_sel = 0; step(2);
    scan_sel = 1; step(2);
    total++;
    if ({an0, seg0} !== {3'b101, 7'h24}) $display("FAIL tear_d1 got an=%b seg=%h want 101/24", an0, seg0);
    else pass++;
    digits = 12'h456; step();
    total++;
    if ({an0, seg0} !== {3'b101, 7'h24}) $display("FAIL tear_d1_hold got an=%b seg=%h want 101/24", an0, seg0);
    else pass++;
    scan_sel = 2; step(2);
    total++;
    if ({an0, seg0} !== {3'b011, 7'h79}) $display("FAIL tear_d2 got an=%b seg=%h want 011/79", an0, seg0);
    else pass++;
    scan_sel = 0; step(2);
    total++;
    if ({an0, seg0} !== {3'b110, 7'h02}) $display("FAIL tear_new_d0 got an=%b seg=%h want 110/02", an0, seg0);
    else pass++;
    scan_sel = 1; step(2);
    total++;
    if ({an0, seg0} !== {3'b101, 7'h12}) $display("FAIL tear_new_d1 got an=%b seg=%h want 101/12", an0, seg0);
    else pass++;
    scan_sel = 2; step(2);
    total++;
    if ({an0, seg0} !== {3'b011, 7'h19}) $display("FAIL tear_new_d2 got an=%b seg=%h want 011/19", an0, seg0);
    else pass++;
  endtask
  task automatic test_invalid_enable;
    scan_sel = 3;
    for (int k = 0; k < 2; k++) begin
      step();
      total++;
      if ({an0, seg0, seg_dp0} !== {3'b111, 7'h7F, 1'b1})
        $display("FAIL sel3 c%0d got an=%b seg=%h dp=%b want 111/7f/1", k, an0, seg0, seg_dp0);
      else pass++;
    end
    enable = 0; scan_sel = 2; step();
    total++;
    if ({an0, seg0, seg_dp0} !== {3'b111, 7'h7F, 1'b1})
      $display("FAIL enable_off got an=%b seg=%h dp=%b want 111/7f/1", an0, seg0, seg_dp0);
    else pass++;
    digits = 12'h789; step(2);
    total++;
    if ({an0, seg0} !== {3'b111, 7'h7F}) $display("FAIL enable_off_hold got an=%b seg=%h want 111/7f", an0, seg0);
    else pass++;
    enable = 1; step();
    total++;
    if (an0 !== 3'b111) $display("FAIL enable_restart_blank got an=%b want 111", an0);
    else pass++;
    step();
    total++;
    if ({an0, seg0} !== {3'b011, 7'h78}) $display("FAIL enable_resnap got an=%b seg=%h want 011/78", an0, seg0);
    else pass++;
  endtask
  task automatic test_leading_zero;
    digits = 12'h007;
    scan_sel = 0; step(2);
    total++;
    if ({an0, seg0} !== {3'b110, 7'h78}) $display("FAIL lz_d0 got an=%b seg=%h want 110/78", an0, seg0);
    else pass++;
    scan_sel = 1; step(2);
    total++;
    if ({an0, seg0} !== {3'b101, lz40}) $display("FAIL lz_d1 got an=%b seg=%h want 101/%h", an0, seg0, lz40);
    else pass++;
    scan_sel = 2; step(2);
    total++;
    if ({an0, seg0} !== {3'b011, lz40}) $display("FAIL lz_d2 got an=%b seg=%h want 011/%h", an0, seg0, lz40);
    else pass++;
    step(4);
  endtask
  task automatic test_reset_mid_drive;
    total++;
    if ({an0, an3} !== {3'b011, 3'b011}) $display("FAIL pre_reset got an0=%b an3=%b want 011/011", an0, an3);
    else pass++;
    #1 rst_n = 0;
    #1;
    total++;
    if ({an0, seg0, seg_dp0, an3, seg3, seg_dp3} !== {3'b111, 7'h7F, 1'b1, 3'b111, 7'h7F, 1'b1})
      $display("FAIL async_reset got an0=%b seg0=%h an3=%b seg3=%h want 111/7f", an0, seg0, an3, seg3);
    else pass++;
    step(2);
    total++;
    if ({an0, an3} !== {3'b111, 3'b111}) $display("FAIL reset_hold got an0=%b an3=%b want 111/111", an0, an3);
    else pass++;
    rst_n = 1;
  endtask
  initial begin
    lz40 = LZ ? 7'h7F : 7'h40;
    #6;
    test_reset_state();
    rst_n = 1;
    step(3);
    test_scan();
    test_blank();
    test_tear();
    test_invalid_enable();
    test_leading_zero();
    test_reset_mid_drive();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
